// File: rtl/pipe_scroller.sv
// ============================================================================
// Module  : pipe_scroller
// Purpose : Scrolls one pipe left once per frame, drives the gap-ROM index,
//           latches the gap Y, and raises a pass pulse and saturating score.
// Config  : PIPE_RANDOM_EN selects LFSR-chosen ROM index on wrap
//           (default: sequential index).
// Rev     : 1.0
// ============================================================================
`default_nettype none

module pipe_scroller #(
  parameter int SCREEN_W = 640,
  parameter int STEP     = 2,
  parameter int BIRD_X   = 160
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       stop,
  input  logic [9:0] rom_y,
  output logic [1:0] rom_idx,
  output logic [9:0] pipe_x,
  output logic [9:0] gap_y,
  output logic       pass,
  output logic [7:0] score,
  output logic       running
);

  localparam logic [9:0] SCREEN_W_10 = 10'(SCREEN_W);
  localparam logic [9:0] STEP_10     = 10'(STEP);
  localparam logic [9:0] BIRD_X_10   = 10'(BIRD_X);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    HALT = 2'd3
  } state_t;

  state_t     state_q,   state_d;
  logic [9:0] pipe_x_q,  pipe_x_d;
  logic [9:0] gap_y_q,   gap_y_d;
  logic [1:0] rom_idx_q, rom_idx_d;
  logic       pass_q,    pass_d;
  logic [7:0] score_q,   score_d;
  logic       running_q, running_d;

  logic [9:0] pipe_x_dec;
  logic [1:0] next_idx;

  assign pipe_x_dec = pipe_x_q - STEP_10;

`ifdef PIPE_RANDOM_EN
  logic [7:0] lfsr_q, lfsr_d;

  // x^8+x^6+x^5+x^4+1, shifting toward the MSB
  assign lfsr_d   = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  assign next_idx = lfsr_q[1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_q <= 8'h01;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end
`else
  assign next_idx = rom_idx_q + 2'd1;
`endif

  always_comb begin
    state_d   = state_q;
    pipe_x_d  = pipe_x_q;
    gap_y_d   = gap_y_q;
    rom_idx_d = rom_idx_q;
    pass_d    = 1'b0;
    score_d   = score_q;

    case (state_q)
      IDLE, HALT: begin
        if (start) begin
          state_d  = LOAD;
          score_d  = 8'd0;
          pipe_x_d = SCREEN_W_10;
        end
      end
      LOAD: begin
        // rom_y already reflects the registered rom_idx; frame_tick is ignored here
        gap_y_d = rom_y;
        state_d = RUN;
      end
      RUN: begin
        if (stop) begin
          state_d = HALT;
        end else if (frame_tick) begin
          if (pipe_x_q < STEP_10) begin
            pipe_x_d  = SCREEN_W_10;
            rom_idx_d = next_idx;
            state_d   = LOAD;
          end else begin
            pipe_x_d = pipe_x_dec;
            if ((pipe_x_q >= BIRD_X_10) && (pipe_x_dec < BIRD_X_10)) begin
              pass_d  = 1'b1;
              score_d = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    running_d = (state_d == LOAD) || (state_d == RUN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      pipe_x_q  <= SCREEN_W_10;
      gap_y_q   <= 10'd0;
      rom_idx_q <= 2'd0;
      pass_q    <= 1'b0;
      score_q   <= 8'd0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pipe_x_q  <= pipe_x_d;
      gap_y_q   <= gap_y_d;
      rom_idx_q <= rom_idx_d;
      pass_q    <= pass_d;
      score_q   <= score_d;
      running_q <= running_d;
    end
  end

  assign rom_idx = rom_idx_q;
  assign pipe_x  = pipe_x_q;
  assign gap_y   = gap_y_q;
  assign pass    = pass_q;
  assign score   = score_q;
  assign running = running_q;

endmodule

`default_nettype wire
